// File: rtl/vtg_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vtg_pattern_gen
// Purpose  : Video timing generator with selectable test patterns. Produces
//            hsync/vsync/data-valid for a parametrised raster, frame-start and
//            line-end markers, and starts/stops only on frame boundaries.
// Revision : 1.0  initial release
// ============================================================================
module vtg_pattern_gen #(
  parameter int   HACT   = 640,
  parameter int   HFP    = 16,
  parameter int   HSP    = 96,
  parameter int   HBP    = 48,
  parameter int   VACT   = 480,
  parameter int   VFP    = 11,
  parameter int   VSP    = 2,
  parameter int   VBP    = 31,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int   DW     = 8,
  parameter int   CW     = 12
) (
  input  logic            px_clk,
  input  logic            sys_rst,
  input  logic            en_i,
  input  logic [2:0]      mode_i,
  input  logic [3*DW-1:0] solid_i,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            dval_o,
  output logic            sof_o,
  output logic            eol_o,
  output logic [DW-1:0]   rdata_o,
  output logic [DW-1:0]   gdata_o,
  output logic [DW-1:0]   bdata_o,
  output logic [15:0]     frame_cnt_o,
  output logic            busy_o
);

  localparam int c_HTOT = HSP + HBP + HACT + HFP;
  localparam int c_VTOT = VSP + VBP + VACT + VFP;
  // x needs at least 6 bits for the 32-pixel checker and DW bits for ramps
  localparam int c_XW   = (DW > 6) ? DW : 6;

  localparam logic [CW-1:0] c_H_LAST     = CW'(c_HTOT - 1);
  localparam logic [CW-1:0] c_V_LAST     = CW'(c_VTOT - 1);
  localparam logic [CW-1:0] c_H_SYNC_END = CW'(HSP);
  localparam logic [CW-1:0] c_V_SYNC_END = CW'(VSP);
  localparam logic [CW-1:0] c_H_ACT_BEG  = CW'(HSP + HBP);
  localparam logic [CW-1:0] c_H_ACT_END  = CW'(HSP + HBP + HACT);
  localparam logic [CW-1:0] c_H_ACT_LAST = CW'(HSP + HBP + HACT - 1);
  localparam logic [CW-1:0] c_V_ACT_BEG  = CW'(VSP + VBP);
  localparam logic [CW-1:0] c_V_ACT_END  = CW'(VSP + VBP + VACT);
  localparam logic [CW-1:0] c_BAR_LAST   = CW'(HACT / 8 - 1);
  localparam logic [DW-1:0] c_FULL       = {DW{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_hcnt;
  logic [CW-1:0]   r_vcnt;
  logic [CW-1:0]   w_hcnt_nxt;
  logic [CW-1:0]   w_vcnt_nxt;
  logic            w_fcnt_inc;
  logic [15:0]     r_frame_cnt;
  logic [2:0]      r_mode;
  logic [3*DW-1:0] r_solid;
  logic [CW-1:0]   r_bar_px;
  logic [2:0]      r_bar_idx;

  logic            w_run;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_h_act;
  logic            w_v_act;
  logic            w_act;
  logic            w_hs_on;
  logic            w_vs_on;
  logic            w_frame_top;
  logic [c_XW-1:0] w_x;
  logic            w_y5;
  logic [DW-1:0]   w_ramp;
  logic [DW-1:0]   w_r;
  logic [DW-1:0]   w_g;
  logic [DW-1:0]   w_b;

  logic            r_hsync;
  logic            r_vsync;
  logic            r_dval;
  logic            r_sof;
  logic            r_eol;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_gdata;
  logic [DW-1:0]   r_bdata;

  assign w_run       = (r_state == S_RUN);
  assign w_h_last    = (r_hcnt == c_H_LAST);
  assign w_v_last    = (r_vcnt == c_V_LAST);
  assign w_h_act     = (r_hcnt >= c_H_ACT_BEG) && (r_hcnt < c_H_ACT_END);
  assign w_v_act     = (r_vcnt >= c_V_ACT_BEG) && (r_vcnt < c_V_ACT_END);
  assign w_act       = w_run && w_h_act && w_v_act;
  assign w_hs_on     = w_run && (r_hcnt < c_H_SYNC_END);
  assign w_vs_on     = w_run && (r_vcnt < c_V_SYNC_END);
  assign w_frame_top = w_run && (r_hcnt == '0) && (r_vcnt == '0);

  // Pixel coordinates relative to the active window; only bit 5 of y matters
  assign w_x    = c_XW'(r_hcnt) - c_XW'(HSP + HBP);
  assign w_y5   = ((c_XW'(r_vcnt) - c_XW'(VSP + VBP)) & c_XW'(32)) != '0;
  assign w_ramp = w_x[DW-1:0] + r_frame_cnt[DW-1:0];

  // Next-state and counter sequencing; stopping only at the last frame pixel
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    w_fcnt_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hcnt_nxt = '0;
        w_vcnt_nxt = '0;
        if (en_i) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_h_last) begin
          w_hcnt_nxt = '0;
          if (w_v_last) begin
            w_vcnt_nxt = '0;
            w_fcnt_inc = 1'b1;
            if (!en_i) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_vcnt_nxt = r_vcnt + 1'b1;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hcnt_nxt  = '0;
        w_vcnt_nxt  = '0;
      end
    endcase
  end

  // State, raster counters and completed-frame counter
  always_ff @(posedge px_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
      if (w_fcnt_inc) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Shadow pattern controls, latched once per frame so a frame never tears
  always_ff @(posedge px_clk) begin
    if (sys_rst) begin
      r_mode  <= 3'd0;
      r_solid <= '0;
    end else if (w_frame_top) begin
      r_mode  <= mode_i;
      r_solid <= solid_i;
    end
  end

  // Colour-bar position: pixel-within-bar and bar index, cleared outside active
  always_ff @(posedge px_clk) begin
    if (sys_rst || !(w_run && w_h_act)) begin
      r_bar_px  <= '0;
      r_bar_idx <= 3'd0;
    end else if (r_bar_px == c_BAR_LAST) begin
      r_bar_px  <= '0;
      r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_px <= r_bar_px + 1'b1;
    end
  end

  // Pattern colour for the current counter position
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (r_mode)
      3'd1: begin
        w_r = r_solid[3*DW-1:2*DW];
        w_g = r_solid[2*DW-1:DW];
        w_b = r_solid[DW-1:0];
      end
      3'd2: begin
        // Bar order W,Y,C,G,M,R,B,K maps to inverted index bits
        w_r = {DW{~r_bar_idx[1]}};
        w_g = {DW{~r_bar_idx[2]}};
        w_b = {DW{~r_bar_idx[0]}};
      end
      3'd3: begin
        w_r = w_x[DW-1:0];
        w_g = w_x[DW-1:0];
        w_b = w_x[DW-1:0];
      end
      3'd4: begin
        if (w_x[5] ^ w_y5) begin
          w_r = c_FULL;
          w_g = c_FULL;
          w_b = c_FULL;
        end
      end
      3'd5: begin
        w_r = w_ramp;
        w_g = w_ramp;
        w_b = w_ramp;
      end
      default: begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
      end
    endcase
  end

  // Output register stage; everything leaves one cycle after its position
  always_ff @(posedge px_clk) begin
    if (sys_rst) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_dval  <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_rdata <= '0;
      r_gdata <= '0;
      r_bdata <= '0;
    end else begin
      r_hsync <= w_hs_on ? HS_POL : ~HS_POL;
      r_vsync <= w_vs_on ? VS_POL : ~VS_POL;
      r_dval  <= w_act;
      r_sof   <= w_act && (r_hcnt == c_H_ACT_BEG) && (r_vcnt == c_V_ACT_BEG);
      r_eol   <= w_act && (r_hcnt == c_H_ACT_LAST);
      r_rdata <= w_act ? w_r : '0;
      r_gdata <= w_act ? w_g : '0;
      r_bdata <= w_act ? w_b : '0;
    end
  end

  assign hsync_o     = r_hsync;
  assign vsync_o     = r_vsync;
  assign dval_o      = r_dval;
  assign sof_o       = r_sof;
  assign eol_o       = r_eol;
  assign rdata_o     = r_rdata;
  assign gdata_o     = r_gdata;
  assign bdata_o     = r_bdata;
  assign frame_cnt_o = r_frame_cnt;
  assign busy_o      = w_run;

endmodule
`default_nettype wire

// File: tb/tb_vtg_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vtg_pattern_gen
// Purpose  : Directed bench for vtg_pattern_gen on a 25x8 raster (16x4 active)
//            with a second instance using active-high sync polarity.
// Revision : 1.0  initial release
// ============================================================================
module tb_vtg_pattern_gen;

  logic        px_clk;
  logic        sys_rst;
  logic        en_i;
  logic [2:0]  mode_i;
  logic [23:0] solid_i;

  logic        hsync_o, vsync_o, dval_o, sof_o, eol_o, busy_o;
  logic [7:0]  rdata_o, gdata_o, bdata_o;
  logic [15:0] frame_cnt_o;

  logic        hsync2, vsync2, dval2, sof2, eol2, busy2;
  logic [7:0]  rdata2, gdata2, bdata2;
  logic [15:0] frame_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  vtg_pattern_gen #(
    .HACT(16), .HFP(2), .HSP(3), .HBP(4),
    .VACT(4), .VFP(1), .VSP(1), .VBP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .DW(8), .CW(12)
  ) dut (
    .px_clk(px_clk), .sys_rst(sys_rst), .en_i(en_i), .mode_i(mode_i),
    .solid_i(solid_i), .hsync_o(hsync_o), .vsync_o(vsync_o), .dval_o(dval_o),
    .sof_o(sof_o), .eol_o(eol_o), .rdata_o(rdata_o), .gdata_o(gdata_o),
    .bdata_o(bdata_o), .frame_cnt_o(frame_cnt_o), .busy_o(busy_o)
  );

  vtg_pattern_gen #(
    .HACT(16), .HFP(2), .HSP(3), .HBP(4),
    .VACT(4), .VFP(1), .VSP(1), .VBP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .DW(8), .CW(12)
  ) dut2 (
    .px_clk(px_clk), .sys_rst(sys_rst), .en_i(en_i), .mode_i(mode_i),
    .solid_i(solid_i), .hsync_o(hsync2), .vsync_o(vsync2), .dval_o(dval2),
    .sof_o(sof2), .eol_o(eol2), .rdata_o(rdata2), .gdata_o(gdata2),
    .bdata_o(bdata2), .frame_cnt_o(frame_cnt2), .busy_o(busy2)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int mode, input int x, input int y,
                                          input int fc, input logic [23:0] sol);
    logic [7:0] v;
    exp_rgb = 24'h0;
    case (mode)
      1: exp_rgb = sol;
      2: begin
        case (x / 2)
          0: exp_rgb = 24'hFFFFFF;
          1: exp_rgb = 24'hFFFF00;
          2: exp_rgb = 24'h00FFFF;
          3: exp_rgb = 24'h00FF00;
          4: exp_rgb = 24'hFF00FF;
          5: exp_rgb = 24'hFF0000;
          6: exp_rgb = 24'h0000FF;
          default: exp_rgb = 24'h000000;
        endcase
      end
      3: begin
        v = 8'(x);
        exp_rgb = {v, v, v};
      end
      4: exp_rgb = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      5: begin
        v = 8'(x + fc);
        exp_rgb = {v, v, v};
      end
      default: exp_rgb = 24'h0;
    endcase
  endfunction

  // Called with outputs showing raster position 0 of a frame; walks 200 cycles.
  task automatic check_frame(input int mode, input int fc, input logic [23:0] sol,
                             input logic [2:0] nmode, input logic [23:0] nsol,
                             input bit drop);
    for (int p = 0; p < 200; p++) begin
      int h;
      int v;
      logic e_hs, e_vs, e_dv, e_sof, e_eol, e_busy;
      logic [15:0] e_fc;
      logic [23:0] e_rgb;
      h      = p % 25;
      v      = p / 25;
      e_hs   = (h >= 3);
      e_vs   = (v >= 1);
      e_dv   = (h >= 7) && (h < 23) && (v >= 3) && (v < 7);
      e_sof  = e_dv && (h == 7) && (v == 3);
      e_eol  = e_dv && (h == 22);
      e_busy = !((p == 199) && drop);
      e_fc   = (p == 199) ? 16'(fc + 1) : 16'(fc);
      e_rgb  = e_dv ? exp_rgb(mode, h - 7, v - 3, fc, sol) : 24'h0;
      chk("hsync", hsync_o, e_hs);
      chk("vsync", vsync_o, e_vs);
      chk("dval", dval_o, e_dv);
      chk("sof", sof_o, e_sof);
      chk("eol", eol_o, e_eol);
      chk("rgb", {rdata_o, gdata_o, bdata_o}, e_rgb);
      chk("busy", busy_o, e_busy);
      chk("frame_cnt", frame_cnt_o, e_fc);
      chk("hsync_pol1", hsync2, !e_hs);
      chk("vsync_pol1", vsync2, !e_vs);
      if (drop && p == 50) en_i = 1'b0;
      if (p == 100) begin
        mode_i  = nmode;
        solid_i = nsol;
      end
      tick();
    end
  endtask

  task automatic check_idle(input string tag, input logic [15:0] fc);
    chk({tag, "_hsync"}, hsync_o, 1'b1);
    chk({tag, "_vsync"}, vsync_o, 1'b1);
    chk({tag, "_dval"}, dval_o, 1'b0);
    chk({tag, "_sof"}, sof_o, 1'b0);
    chk({tag, "_eol"}, eol_o, 1'b0);
    chk({tag, "_rgb"}, {rdata_o, gdata_o, bdata_o}, 24'h0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_frame_cnt"}, frame_cnt_o, fc);
    chk({tag, "_hsync_pol1"}, hsync2, 1'b0);
    chk({tag, "_vsync_pol1"}, vsync2, 1'b0);
  endtask

  // Raise en_i from IDLE and leave outputs showing position 0 of the frame
  task automatic start_run();
    en_i = 1'b1;
    tick();
    chk("start_busy", busy_o, 1'b1);
    chk("start_hsync_idle", hsync_o, 1'b1);
    tick();
  endtask

  initial begin
    sys_rst = 1'b1;
    en_i    = 1'b0;
    mode_i  = 3'd0;
    solid_i = 24'h0;
    tick();
    tick();
    tick();
    check_idle("reset", 16'd0);
    sys_rst = 1'b0;
    tick();
    check_idle("idle", 16'd0);

    start_run();
    // Frame 0: black; mode switched to bars mid-frame must not tear it
    check_frame(0, 0, 24'h0, 3'd2, 24'h0, 1'b0);
    // Frame 1: colour bars; switch to grey ramp mid-frame
    check_frame(2, 1, 24'h0, 3'd3, 24'h0, 1'b0);
    // Frame 2: grey ramp; en_i dropped at cycle 50, frame must still finish
    check_frame(3, 2, 24'h0, 3'd5, 24'h0, 1'b1);
    check_idle("stopped", 16'd3);
    repeat (5) tick();
    check_idle("stopped_hold", 16'd3);

    start_run();
    // Frames 3,4: moving ramp keyed to frame count
    check_frame(5, 3, 24'h0, 3'd5, 24'h0, 1'b0);
    check_frame(5, 4, 24'h0, 3'd1, 24'h12_34_56, 1'b0);
    // Frame 5: solid colour
    check_frame(1, 5, 24'h12_34_56, 3'd4, 24'hAB_CD_EF, 1'b0);
    // Frame 6: checker (all black inside a 16x4 window)
    check_frame(4, 6, 24'hAB_CD_EF, 3'd4, 24'h0, 1'b0);

    // Reset in the middle of an active line (h = 10, v = 3)
    repeat (85) tick();
    chk("pre_reset_dval", dval_o, 1'b1);
    chk("pre_reset_frame_cnt", frame_cnt_o, 16'd7);
    sys_rst = 1'b1;
    tick();
    check_idle("mid_reset", 16'd0);
    sys_rst = 1'b0;
    tick();
    chk("post_reset_busy", busy_o, 1'b1);
    tick();
    check_frame(4, 0, 24'h0, 3'd0, 24'h0, 1'b1);
    check_idle("final", 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vtg_pattern_gen.md
# vtg_pattern_gen

Parametrised video timing and test-pattern generator for the pixel-clock domain. It produces hsync/vsync/data-valid timing for any raster geometry, with programmable sync polarity and a configurable colour depth. It also produces one of six selectable test patterns with frame-start and line-end markers, and can be started and stopped cleanly on frame boundaries. It drives display/output paths in place of real video during bring-up and verification.

## Interface
- HACT, 640, active pixels per line (multiple of 8, ≥ 8)
- HFP, 16, horizontal front porch, pixels (≥ 1)
- HSP, 96, hsync pulse width, pixels (≥ 1)
- HBP, 48, horizontal back porch, pixels (≥ 1)
- VACT, 480, active lines per frame (≥ 1)
- VFP, 11, vertical front porch, lines (≥ 1)
- VSP, 2, vsync pulse width, lines (≥ 1)
- VBP, 31, vertical back porch, lines (≥ 1)
- HS_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- VS_POL, 0, vsync active level
- DW, 8, bits per colour channel (4..12)
- CW, 12, width of the h/v counters (must hold HTOT-1 and VTOT-1)
- px_clk  in  1  pixel clock; single clock domain
- sys_rst  in  1  synchronous, active-high reset
- en_i  in  1  run request; level-sensitive
- mode_i  in  3  pattern select; sampled at frame start
- solid_i  in  3*DW  {R,G,B} colour for mode 1; sampled at frame start
- hsync_o  out  1  horizontal sync, polarity HS_POL
- vsync_o  out  1  vertical sync, polarity VS_POL
- dval_o  out  1  high on active pixels
- sof_o  out  1  one-cycle pulse on the first active pixel of a frame
- eol_o  out  1  one-cycle pulse on the last active pixel of each line
- rdata_o / gdata_o / bdata_o  out  DW each  pixel colour; 0 when dval_o = 0
- frame_cnt_o  out  16  completed-frame count; wraps 0xFFFF→0
- busy_o  out  1  high while in RUN

## Operation
- HTOT = HSP+HBP+HACT+HFP; VTOT = VSP+VBP+VACT+VFP.
- Line order by hcnt: sync [0, HSP), back porch [HSP, HSP+HBP), active [HSP+HBP, HSP+HBP+HACT), front porch to HTOT-1. Frame order by vcnt uses the same layout with V parameters.
- hcnt wraps HTOT-1→0 and increments vcnt at the same time. vcnt wraps VTOT-1→0.
- Active pixel means both hcnt and vcnt are in their active ranges. x = hcnt-(HSP+HBP), y = vcnt-(VSP+VBP).
- FSM has two states, IDLE and RUN.
  - IDLE: counters are held at 0 and outputs are inactive. If en_i = 1, go to RUN; the first RUN cycle has hcnt = vcnt = 0.
  - RUN: count. At the last pixel of the frame (hcnt = HTOT-1, vcnt = VTOT-1), frame_cnt increments. Then, if en_i = 0, go to IDLE; otherwise wrap to a new frame.
  - Dropping en_i mid-frame never truncates the frame.
- mode and solid are captured into shadow registers when hcnt = vcnt = 0 in RUN, so a mode change never tears a frame.
- Patterns (full scale = all ones, DW bits):
  - 0: black.
  - 1: solid_i.
  - 2: 8 vertical bars, each HACT/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. The bar index comes from a sub-counter, not a divider.
  - 3: grey ramp; R = G = B = x[DW-1:0].
  - 4: 32×32 checker; white if x[5]^y[5] else black.
  - 5: moving ramp; R = G = B = (x + frame_cnt)[DW-1:0], modulo 2^DW.
  - 6, 7: black.

## Timing
- All outputs are registered. Outputs for counter position (h, v) appear exactly 1 cycle after the counters hold (h, v). Sync, dval, data and markers stay mutually aligned.
- Reset, and IDLE, give: hsync_o = ~HS_POL, vsync_o = ~VS_POL, dval_o = 0, sof_o = 0, eol_o = 0, data = 0, busy_o = 0. Reset additionally gives frame_cnt_o = 0 and shadow mode = 0.
- Reset asserted mid-frame returns the block to IDLE on the next edge. There is no partial-frame completion.
- vsync changes level only on cycles where hcnt = 0, so its edges align with hsync leading edges.
- busy_o goes high 1 cycle after the IDLE→RUN decision and low 1 cycle after the last frame pixel.
- frame_cnt_o updates on the cycle after the last frame pixel. Mode 5 uses the value current during that frame.

## Test plan
Parameters for all scenarios unless noted: HACT = 16, HFP = 2, HSP = 3, HBP = 4, VACT = 4, VFP = 1, VSP = 1, VBP = 2. This gives HTOT = 25, VTOT = 8, 200 cycles per frame.

- Reset, then en_i = 1 held -> hsync low for 3 of every 25 cycles. vsync low for the first 25 cycles of every 200. dval high for 16 consecutive cycles on 4 lines per frame, 64 active pixels per frame. frame_cnt_o reads 1, 2, 3 at 200-cycle intervals.
- mode 2, DW = 8 -> each active line shows 2 pixels of each colour in order, starting with FF,FF,FF and ending with 00,00,00. sof_o pulses once per frame together with the first dval. eol_o pulses on the 16th dval cycle of each line.
- mode changed 0→3 mid-frame -> the current frame stays black. The next frame's line shows ramp values 0..15.
- en_i dropped at the 50th cycle of frame 2 -> frame 2 completes fully, busy_o falls, and outputs sit at idle levels. Re-asserting en_i restarts with vsync at the first cycle of RUN.
- HS_POL = VS_POL = 1, sys_rst pulsed mid-active line -> the next cycle shows hsync_o = 0, vsync_o = 0, dval_o = 0, frame_cnt_o = 0.
- mode 5, frame_cnt driven toward 0xFFFF -> pixel x = 0 equals frame_cnt[7:0] in each frame. frame_cnt wraps to 0 and the ramp continues.
